// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-wide memory bus controller for the cpu.
// Arbitrates instruction fetch (always 4 bytes, read only) against the
// load/store unit (1/2/4 bytes, read or write). Each grant becomes one bus
// cycle per byte, assembled little-endian. rdy_in = 0 freezes everything.
// A read that was paused re-presents its last un-captured address once
// before continuing, so the registered byte lost during the pause is re-read.
module mem_ctrl #(
  parameter bit LS_FIRST = 1'b1
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        ls_req,
  input  logic        ls_wr,
  input  logic [1:0]  ls_size,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_done,
  output logic [31:0] ls_rdata,
  input  logic        flush,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    RD_LAST = 3'd2,
    WR      = 3'd3,
    RESYNC  = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_base,  w_base_nxt;
  logic [31:0] r_wdata, w_wdata_nxt;
  logic [31:0] r_data,  w_data_nxt;
  logic [2:0]  r_k,     w_k_nxt;      // index of the next byte to issue
  logic [2:0]  r_n,     w_n_nxt;      // beat count of the current transfer
  logic        r_is_ls, w_is_ls_nxt;  // owner of the current transfer
  logic        w_grant_ls;
  logic        w_grant_if;
  logic        w_abort_if;
  logic [1:0]  w_cap_idx;             // result byte captured this cycle (k-1)
  logic [2:0]  w_a_off;               // offset added to base for mem_a

  // Beat count for a load/store size code; the reserved code acts as a word.
  function automatic logic [2:0] beats(input logic [1:0] size);
    case (size)
      2'b00:   beats = 3'd1;
      2'b01:   beats = 3'd2;
      default: beats = 3'd4;
    endcase
  endfunction

  // Little-endian byte select from a 32-bit word.
  function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] idx);
    case (idx)
      2'd0:    get_byte = w[7:0];
      2'd1:    get_byte = w[15:8];
      2'd2:    get_byte = w[23:16];
      default: get_byte = w[31:24];
    endcase
  endfunction

  // Little-endian byte insert into a 32-bit word.
  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] idx,
                                           input logic [7:0] b);
    put_byte = w;
    case (idx)
      2'd0:    put_byte[7:0]   = b;
      2'd1:    put_byte[15:8]  = b;
      2'd2:    put_byte[23:16] = b;
      default: put_byte[31:24] = b;
    endcase
  endfunction

  // Flush only blocks a new fetch grant; an LS request may still win in that cycle.
  assign w_grant_ls = ls_req & (LS_FIRST | ~if_req | flush);
  assign w_grant_if = if_req & ~flush & ~w_grant_ls;
  assign w_abort_if = flush & ~r_is_ls;
  assign w_cap_idx  = r_k[1:0] - 2'd1;

  // Next-state and datapath update; everything holds while the bus is paused.
  always_comb begin
    w_state_nxt = r_state;
    w_base_nxt  = r_base;
    w_wdata_nxt = r_wdata;
    w_data_nxt  = r_data;
    w_k_nxt     = r_k;
    w_n_nxt     = r_n;
    w_is_ls_nxt = r_is_ls;
    if (!rdy_in) begin
      // Counters freeze; a paused read is marked so it re-presents an address on resume.
      if (r_state == RD || r_state == RD_LAST) begin
        w_state_nxt = RESYNC;
      end else begin
        w_state_nxt = r_state;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_ls) begin
            w_base_nxt  = ls_addr;
            w_n_nxt     = beats(ls_size);
            w_wdata_nxt = ls_wdata;
            w_is_ls_nxt = 1'b1;
            w_data_nxt  = 32'h0000_0000;
            w_k_nxt     = 3'd0;
            w_state_nxt = ls_wr ? WR : RD;
          end else if (w_grant_if) begin
            w_base_nxt  = if_addr;
            w_n_nxt     = 3'd4;
            w_wdata_nxt = 32'h0000_0000;
            w_is_ls_nxt = 1'b0;
            w_data_nxt  = 32'h0000_0000;
            w_k_nxt     = 3'd0;
            w_state_nxt = RD;
          end else begin
            w_state_nxt = IDLE;
          end
        end
        RD: begin
          if (w_abort_if) begin
            w_state_nxt = IDLE;
          end else begin
            if (r_k != 3'd0) begin
              w_data_nxt = put_byte(r_data, w_cap_idx, mem_din);
            end else begin
              w_data_nxt = r_data;
            end
            w_k_nxt = r_k + 3'd1;
            if (r_k == r_n - 3'd1) begin
              w_state_nxt = RD_LAST;
            end else begin
              w_state_nxt = RD;
            end
          end
        end
        RD_LAST: begin
          if (w_abort_if) begin
            w_state_nxt = IDLE;
          end else begin
            w_data_nxt  = put_byte(r_data, w_cap_idx, mem_din);
            w_state_nxt = DONE;
          end
        end
        RESYNC: begin
          if (w_abort_if) begin
            w_state_nxt = IDLE;
          end else if (r_k == r_n) begin
            w_state_nxt = RD_LAST;
          end else begin
            w_state_nxt = RD;
          end
        end
        WR: begin
          w_k_nxt = r_k + 3'd1;
          if (r_k == r_n - 3'd1) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = WR;
          end
        end
        DONE: begin
          w_state_nxt = IDLE;
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers; reset abandons any transfer without a done pulse.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= IDLE;
      r_base  <= 32'h0000_0000;
      r_wdata <= 32'h0000_0000;
      r_data  <= 32'h0000_0000;
      r_k     <= 3'd0;
      r_n     <= 3'd0;
      r_is_ls <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_base  <= w_base_nxt;
      r_wdata <= w_wdata_nxt;
      r_data  <= w_data_nxt;
      r_k     <= w_k_nxt;
      r_n     <= w_n_nxt;
      r_is_ls <= w_is_ls_nxt;
    end
  end

  // Bus drive: write strobe is gated by rdy_in; RESYNC/RD_LAST point at the last issued byte.
  always_comb begin
    mem_wr   = 1'b0;
    mem_dout = 8'h00;
    w_a_off  = r_k;
    case (r_state)
      WR: begin
        mem_wr   = rdy_in;
        mem_dout = get_byte(r_wdata, r_k[1:0]);
      end
      RD_LAST, RESYNC: begin
        w_a_off = (r_k == 3'd0) ? 3'd0 : (r_k - 3'd1);
      end
      default: begin
        w_a_off = r_k;
      end
    endcase
  end

  assign mem_a    = r_base + {29'd0, w_a_off};
  assign if_done  = (r_state == DONE) & rdy_in & ~r_is_ls & ~flush;
  assign ls_done  = (r_state == DONE) & rdy_in & r_is_ls;
  assign if_data  = r_data;
  assign ls_rdata = r_data;
  assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed and randomized checks of mem_ctrl against a byte-array
// reference model. Instance dut uses LS_FIRST=1, dut_b uses LS_FIRST=0.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n_in, rdy_in, flush;
  logic [7:0]  mem_din, mem_dout, b_mem_din, b_mem_dout;
  logic [31:0] mem_a, b_mem_a;
  logic        mem_wr, b_mem_wr;
  logic        if_req, b_if_req, if_done, b_if_done;
  logic [31:0] if_addr, if_data, b_if_data;
  logic        ls_req, b_ls_req, ls_wr, ls_done, b_ls_done;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr, ls_wdata, ls_rdata, b_ls_rdata;
  logic        busy, b_busy;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] last_data;

  // Bench-side RAM: a folded store of written bytes over default contents.
  bit [7:0]    bus_mem [16384];
  bit          bus_vld [16384];
  // Reference model memory, full 32-bit addresses.
  logic [7:0]  ref_mem [logic [31:0]];

  mem_ctrl #(.LS_FIRST(1'b1)) dut (
    .clk_in(clk), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .ls_req(ls_req), .ls_wr(ls_wr), .ls_size(ls_size), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .flush(flush), .busy(busy)
  );

  mem_ctrl #(.LS_FIRST(1'b0)) dut_b (
    .clk_in(clk), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
    .mem_din(b_mem_din), .mem_dout(b_mem_dout), .mem_a(b_mem_a), .mem_wr(b_mem_wr),
    .if_req(b_if_req), .if_addr(if_addr), .if_done(b_if_done), .if_data(b_if_data),
    .ls_req(b_ls_req), .ls_wr(ls_wr), .ls_size(ls_size), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_done(b_ls_done), .ls_rdata(b_ls_rdata),
    .flush(flush), .busy(b_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 8'h11;
      32'h0000_0101: return 8'h22;
      32'h0000_0102: return 8'h33;
      32'h0000_0103: return 8'h44;
      default:       return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'hA5;
    endcase
  endfunction

  function automatic logic [7:0] bus_rd(input logic [31:0] a);
    if (bus_vld[a[13:0]]) return bus_mem[a[13:0]];
    return init_byte(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_byte(a);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input int nb);
    logic [31:0] r;
    r = 32'h0;
    for (int i = 0; i < nb; i++) r[8*i +: 8] = ref_rd(a + 32'(i));
    return r;
  endfunction

  // Synchronous RAM: read data appears the cycle after the address.
  always @(posedge clk) begin
    if (mem_wr) begin
      bus_mem[mem_a[13:0]] <= mem_dout;
      bus_vld[mem_a[13:0]] <= 1'b1;
    end
    mem_din   <= bus_rd(mem_a);
    b_mem_din <= bus_rd(b_mem_a);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One transfer from request to done; jitter randomly pauses (and flushes LS).
  task automatic run_txn(input bit is_if, input bit wr, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata, input bit jitter);
    int          nb, lat, n;
    bit          paused, seen, done, other;
    logic [31:0] exp;
    nb  = is_if ? 4 : (size == 2'b00 ? 1 : (size == 2'b01 ? 2 : 4));
    lat = wr ? nb + 1 : nb + 2;
    exp = ref_load(addr, nb);
    if (wr) begin
      for (int i = 0; i < nb; i++) ref_mem[addr + 32'(i)] = wdata[8*i +: 8];
    end
    @(negedge clk);
    if (is_if) begin
      if_addr = addr; if_req = 1'b1;
    end else begin
      ls_addr = addr; ls_wr = wr; ls_size = size; ls_wdata = wdata; ls_req = 1'b1;
    end
    paused = 1'b0; seen = 1'b0;
    for (n = 1; n <= 200 && !seen; n++) begin
      @(negedge clk);
      if (!rdy_in) chk("wr_while_paused", {31'd0, mem_wr}, 32'd0);
      if (!paused && n <= nb) begin
        chk("bus_addr", mem_a, addr + 32'(n - 1));
        chk("bus_wr", {31'd0, mem_wr}, {31'd0, wr});
        if (wr) chk("bus_dout", {24'd0, mem_dout}, {24'd0, wdata[8*(n-1) +: 8]});
      end
      done  = is_if ? if_done : ls_done;
      other = is_if ? ls_done : if_done;
      chk("other_done", {31'd0, other}, 32'd0);
      if (done) begin
        seen = 1'b1;
        if (!paused) chk("done_latency", 32'(n), 32'(lat));
        last_data = is_if ? if_data : ls_rdata;
        if (!wr) chk(is_if ? "fetch_data" : "load_data", last_data, exp);
        if_req = 1'b0; ls_req = 1'b0;
      end else if (jitter) begin
        rdy_in = ($urandom_range(0, 3) != 0);
        if (!rdy_in) paused = 1'b1;
        if (!is_if) flush = $urandom_range(0, 1) != 0;
      end
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
    rdy_in = 1'b1; flush = 1'b0; if_req = 1'b0; ls_req = 1'b0;
  endtask

  initial begin
    int          a_ls_n, a_if_n, b_ls_n, b_if_n, done_n;
    logic [31:0] a_ls_d, a_if_d, b_ls_d, b_if_d, d;
    logic [31:0] addr;
    bit          is_if, wr;
    rst_n_in = 1'b0; rdy_in = 1'b1; flush = 1'b0;
    if_req = 1'b0; b_if_req = 1'b0; ls_req = 1'b0; b_ls_req = 1'b0;
    if_addr = 32'h0; ls_wr = 1'b0; ls_size = 2'b00; ls_addr = 32'h0; ls_wdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("reset_mem_a", mem_a, 32'h0);
    chk("reset_ctl", {24'd0, mem_dout}, 32'd0);
    chk("reset_flags", {27'd0, mem_wr, if_done, ls_done, busy, b_busy}, 32'd0);
    chk("reset_data", if_data | ls_rdata, 32'h0);
    rst_n_in = 1'b1;

    // Word fetch, half store, byte load of a stored byte.
    run_txn(1'b1, 1'b0, 2'b10, 32'h0000_0100, 32'h0, 1'b0);
    chk("fetch_word", last_data, 32'h4433_2211);
    run_txn(1'b0, 1'b1, 2'b01, 32'h0000_2001, 32'h0000_ABCD, 1'b0);
    chk("store_byte0", {24'd0, bus_rd(32'h2001)}, 32'h0000_00CD);
    chk("store_byte1", {24'd0, bus_rd(32'h2002)}, 32'h0000_00AB);
    run_txn(1'b0, 1'b0, 2'b00, 32'h0000_2002, 32'h0, 1'b0);
    chk("load_after_store", last_data, 32'h0000_00AB);

    // Arbitration: both requests rise together on both instances.
    ls_wr = 1'b0; ls_size = 2'b10; ls_addr = 32'h0000_0300; if_addr = 32'h0000_0100;
    a_ls_n = 0; a_if_n = 0; b_ls_n = 0; b_if_n = 0;
    a_ls_d = 32'h0; a_if_d = 32'h0; b_ls_d = 32'h0; b_if_d = 32'h0;
    @(negedge clk);
    if_req = 1'b1; ls_req = 1'b1; b_if_req = 1'b1; b_ls_req = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      chk("b_no_write", {23'd0, b_mem_wr, b_mem_dout}, 32'd0);
      if (ls_done && ls_req)     begin a_ls_n = n; a_ls_d = ls_rdata;   ls_req = 1'b0;   end
      if (if_done && if_req)     begin a_if_n = n; a_if_d = if_data;    if_req = 1'b0;   end
      if (b_ls_done && b_ls_req) begin b_ls_n = n; b_ls_d = b_ls_rdata; b_ls_req = 1'b0; end
      if (b_if_done && b_if_req) begin b_if_n = n; b_if_d = b_if_data;  b_if_req = 1'b0; end
    end
    chk("arb_lsfirst_ls_cycle", 32'(a_ls_n), 32'd6);
    chk("arb_lsfirst_if_cycle", 32'(a_if_n), 32'd13);
    chk("arb_iffirst_if_cycle", 32'(b_if_n), 32'd6);
    chk("arb_iffirst_ls_cycle", 32'(b_ls_n), 32'd13);
    chk("arb_lsfirst_ls_data", a_ls_d, ref_load(32'h300, 4));
    chk("arb_lsfirst_if_data", a_if_d, 32'h4433_2211);
    chk("arb_iffirst_ls_data", b_ls_d, ref_load(32'h300, 4));
    chk("arb_iffirst_if_data", b_if_d, 32'h4433_2211);

    // Pause for three cycles after byte 1 of a word fetch.
    done_n = 0; d = 32'h0;
    @(negedge clk);
    if_addr = 32'h0000_0100; if_req = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (!rdy_in) chk("pause_wr", {31'd0, mem_wr}, 32'd0);
      if (n == 6) chk("resync_addr", mem_a, 32'h0000_0101);
      if (if_done && if_req) begin done_n = n; d = if_data; if_req = 1'b0; end
      if (n == 3) rdy_in = 1'b0;
      if (n == 6) rdy_in = 1'b1;
    end
    chk("pause_done_cycle", 32'(done_n), 32'd10);
    chk("pause_data", d, 32'h4433_2211);

    // Flush a fetch at t+3 while a byte load waits.
    done_n = 0; d = 32'h0;
    ls_wr = 1'b0; ls_size = 2'b00; ls_addr = 32'h0000_2002;
    @(negedge clk);
    if_addr = 32'h0000_0100; if_req = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      chk("flush_no_if_done", {31'd0, if_done}, 32'd0);
      if (n == 4) chk("flush_idle", {31'd0, busy}, 32'd0);
      if (n == 5) begin
        chk("flush_ls_busy", {31'd0, busy}, 32'd1);
        chk("flush_ls_addr", mem_a, 32'h0000_2002);
      end
      if (ls_done && ls_req) begin done_n = n; d = ls_rdata; ls_req = 1'b0; end
      if (n == 1) ls_req = 1'b1;
      if (n == 3) begin flush = 1'b1; if_req = 1'b0; end
      if (n == 4) flush = 1'b0;
    end
    chk("flush_ls_done_cycle", 32'(done_n), 32'd7);
    chk("flush_ls_data", d, ref_load(32'h2002, 1));

    // Address wrap at the top of the space.
    run_txn(1'b1, 1'b0, 2'b10, 32'hFFFF_FFFE, 32'h0, 1'b0);

    // Randomized mix with pauses and LS-side flushes.
    for (int i = 0; i < 80; i++) begin
      is_if = ($urandom_range(0, 2) == 0);
      wr    = !is_if && ($urandom_range(0, 1) != 0);
      case ($urandom_range(0, 2))
        0:       addr = 32'h0000_2000 + $urandom_range(0, 63);
        1:       addr = 32'hFFFF_FFF8 + $urandom_range(0, 7);
        default: addr = 32'h0003_1000 + $urandom_range(0, 15);
      endcase
      run_txn(is_if, wr, 2'($urandom_range(0, 3)), addr, $urandom, 1'b1);
    end

    // Reset in the middle of a word load.
    @(negedge clk);
    ls_wr = 1'b0; ls_size = 2'b10; ls_addr = 32'h0000_2004; ls_req = 1'b1;
    repeat (4) @(negedge clk);
    chk("pre_reset_busy", {31'd0, busy}, 32'd1);
    rst_n_in = 1'b0;
    #1;
    chk("async_reset_mem_a", mem_a, 32'h0);
    chk("async_reset_ctl", {23'd0, mem_dout, mem_wr}, 32'd0);
    chk("async_reset_flags", {29'd0, if_done, ls_done, busy}, 32'd0);
    chk("async_reset_data", if_data | ls_rdata, 32'h0);
    ls_req = 1'b0;
    @(negedge clk);
    rst_n_in = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      chk("post_reset_quiet", {30'd0, ls_done, busy}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Byte-wide memory-bus controller inside `cpu`. It drives `mem_a`, `mem_dout` and `mem_wr` and samples `mem_din`.
- It arbitrates between two requesters:
  - instruction fetch (IF): 32-bit reads only;
  - load/store unit (LS): 1/2/4-byte reads and writes.
- Each granted request is sequenced into consecutive single-byte bus cycles, and the bytes are assembled little-endian.
- It honours the top-level `rdy_in` pause used during HCI debug break.

Parameters:
- LS_FIRST, 1: when both requests are pending in IDLE, 1 grants LS and 0 grants IF.

Ports:
- clk_in  input  1  system clock
- rst_n_in  input  1  reset
- rdy_in  input  1  1 = bus usable; 0 = paused (hci active)
- mem_din  input  8  read byte; valid the cycle after its address is presented
- mem_dout  output  8  write byte
- mem_a  output  32  byte address
- mem_wr  output  1  1 = write, 0 = read
- if_req  input  1  fetch request; held with if_addr stable until if_done
- if_addr  input  32  fetch address
- if_done  output  1  one-cycle pulse; if_data valid in this cycle
- if_data  output  32  fetched word
- ls_req  input  1  load/store request; held with other ls_* stable until ls_done
- ls_wr  input  1  1 = store
- ls_size  input  2  00 = byte, 01 = half, 10 = word, 11 = reserved (treated as word)
- ls_addr  input  32  base address
- ls_wdata  input  32  store data; byte k = bits [8k+7:8k]
- ls_done  output  1  one-cycle pulse; ls_rdata valid (loads) in this cycle
- ls_rdata  output  32  load data, zero-extended; sign extension is done by the LSU
- flush  input  1  kill in-flight or pending fetch (branch mispredict)
- busy  output  1  state != IDLE

Behaviour:
- Reset:
  - Reset is asynchronous and active-low: clock clk_in; reset rst_n_in, asynchronous, active-low.
  - Reset forces state IDLE.
  - All outputs go to 0: mem_a, mem_dout, mem_wr, if_done, if_data, ls_done, ls_rdata and busy.
  - Reset asserted mid-transfer abandons the transfer with no done pulse.
- States: IDLE, RD, RD_LAST, WR, RESYNC, DONE.
- Beat count N: 1, 2 or 4 from ls_size; IF always uses N = 4.
- IDLE, cycle t:
  - If rdy_in = 1 and a request is pending, grant per LS_FIRST and latch base, N, wr and wdata.
  - The granted request goes to RD or WR at t+1, with byte counter k = 0.
  - flush = 1 suppresses an IF grant in that cycle.
- Addressing: mem_a = base + k, computed modulo 2^32 so it wraps at 0xFFFFFFFF.
- WR:
  - Drive mem_wr = 1 and mem_dout = wdata byte k, then increment k.
  - After k = N-1, go to DONE.
  - A word store therefore writes at t+1..t+4 and pulses ls_done at t+5.
- RD:
  - Drive mem_wr = 0 and mem_a = base + k.
  - When k ≥ 1, capture mem_din into result byte k-1.
  - After issuing byte N-1, go to RD_LAST, which captures byte N-1 and then goes to DONE.
  - A word read issues at t+1..t+4, captures at t+2..t+5, and pulses done at t+6.
  - Unwritten upper result bytes are 0.
- DONE:
  - Pulse exactly one of if_done / ls_done with registered data, then return to IDLE.
  - The requester drops req on the cycle after done, so no regrant of a stale request is possible.
- rdy_in = 0 in any state:
  - All state and counters freeze.
  - mem_wr is forced to 0 combinationally.
  - No capture occurs, and done is not asserted; a DONE pulse is deferred until rdy_in = 1.
  - Resuming into RD or RD_LAST passes through RESYNC for one cycle. RESYNC presents base + (bytes captured) with mem_wr = 0, then continues normally, so the lost registered byte is re-read.
  - Resuming into WR needs no resync.
- Flush:
  - flush while IF is granted (RD, RD_LAST, RESYNC or DONE) aborts to IDLE next cycle, with if_done suppressed.
  - flush has no effect on an LS transfer; stores are never aborted.
- Simultaneous if_req and ls_req in IDLE: LS_FIRST decides the grant. The loser stays pending and is granted from the next IDLE. There is no fairness counter, because LS traffic is bounded by the pipeline.
- Misalignment is permitted: bytes are simply issued sequentially.
- The IO region (mem_a[17:16] = 11) is accessed exactly like RAM. RESYNC may re-read an IO byte, which is acceptable because pause occurs only on debug break.

Test Plan:
- Word fetch: RAM[0x100..0x103] = 11 22 33 44, if_req with if_addr = 0x100 → mem_a 0x100..0x103 on t+1..t+4, if_done at t+6, if_data = 0x44332211.
- Store then load: store with size = 01, addr = 0x2001, wdata = 0xABCD → writes CD@0x2001 and AB@0x2002, ls_done at t+3. A following byte load of 0x2002 returns ls_rdata = 0x000000AB.
- Arbitration: if_req and ls_req rise in the same cycle with LS_FIRST = 1 → LS is serviced first, IF is granted in the IDLE cycle after ls_done, and both complete with correct data. Repeat with LS_FIRST = 0 and expect IF first.
- Pause: drop rdy_in for 3 cycles after byte 1 of a word read → mem_wr stays 0 throughout, RESYNC re-presents the address of byte 1, and the final data is unchanged (0x44332211).
- Flush: assert flush on t+3 of a fetch → no if_done, IDLE at t+4, and a pending ls_req is granted immediately.
- Reset and wrap: a fetch at 0xFFFFFFFE issues FFFFFFFE, FFFFFFFF, 00000000, 00000001. Asserting rst_n_in low mid-transfer zeroes all outputs asynchronously.
